// File: rtl/mandel_pixel_packer_if.sv
// Pixel stream and DDR3 write-request bundle for mandel_pixel_packer.
// master: pixel source + DDR3 controller side; slave: the packer.
interface mandel_pixel_packer_if;
  logic         frame_start;
  logic         pix_valid;
  logic [15:0]  pix_data;
  logic         pix_ready;
  logic         do_write;
  logic [27:0]  where_write;
  logic [127:0] data_to_write;
  logic         ack;
  logic         is_writing;
  logic         last_write_done;

  modport master (
    output frame_start, pix_valid, pix_data,
    output ack, is_writing,
    input  pix_ready, do_write, where_write,
    input  data_to_write, last_write_done
  );

  modport slave (
    input  frame_start, pix_valid, pix_data,
    input  ack, is_writing,
    output pix_ready, do_write, where_write,
    output data_to_write, last_write_done
  );
endinterface

// File: rtl/mandel_pixel_packer.sv
// Packs 16-bit pixels into 128-bit words and writes them to DDR3.
// Ports: clk, sys_rst (async, active high), bus (slave modport).
module mandel_pixel_packer #(
  parameter int PIXELS_PER_FRAME = 786432,
  parameter int ADDR_STEP        = 8,
  parameter int BASE_ADDR        = 0
) (
  input logic                  clk,
  input logic                  sys_rst,
  mandel_pixel_packer_if.slave bus
);
  localparam int PCW = $clog2(PIXELS_PER_FRAME);
  localparam logic [PCW-1:0] LAST_PIX =
    PCW'(PIXELS_PER_FRAME - 1);
  localparam logic [16:0] WORDS =
    17'(PIXELS_PER_FRAME / 8);
  localparam logic [27:0] BASE = 28'(BASE_ADDR);
  localparam logic [27:0] STEP = 28'(ADDR_STEP);

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_WAIT
  } wstate_t;

  logic           frame_active;
  logic [PCW-1:0] pix_cnt;
  logic [2:0]     pack_cnt;
  logic [127:0]   pack_reg;
  logic [127:0]   word_nxt;
  logic [127:0]   fifo0;
  logic [127:0]   fifo1;
  logic [1:0]     fifo_cnt;
  logic [16:0]    wr_idx;
  logic           stale;
  wstate_t        state;
  logic           accept;
  logic           push;
  logic           pop;

  // Stall only the word-completing pixel when both FIFO slots are full.
  assign bus.pix_ready = frame_active &&
    !(pack_cnt == 3'd7 && fifo_cnt == 2'd2);

  // A frame_start cycle discards any pixel offered alongside it.
  assign accept = bus.pix_valid && bus.pix_ready &&
    !bus.frame_start;
  assign push = accept && pack_cnt == 3'd7;
  assign pop = state == W_IDLE && fifo_cnt != 2'd0 &&
    !bus.frame_start;

  // Slot index: pack_cnt 0 -> bits [127:112].
  always_comb begin
    word_nxt = pack_reg;
    word_nxt[{~pack_cnt, 4'b0000} +: 16] = bus.pix_data;
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      frame_active <= 1'b0;
      pix_cnt      <= '0;
      pack_cnt     <= 3'd0;
      pack_reg     <= '0;
      fifo0        <= '0;
      fifo1        <= '0;
      fifo_cnt     <= 2'd0;
    end else if (bus.frame_start) begin
      frame_active <= 1'b1;
      pix_cnt      <= '0;
      pack_cnt     <= 3'd0;
      fifo_cnt     <= 2'd0;
    end else begin
      if (accept) begin
        pack_reg <= word_nxt;
        pack_cnt <= pack_cnt + 3'd1;
        pix_cnt  <= pix_cnt + PCW'(1);
        if (pix_cnt == LAST_PIX)
          frame_active <= 1'b0;
      end
      unique case ({push, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) fifo0 <= word_nxt;
          else                  fifo1 <= word_nxt;
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          fifo0    <= fifo1;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            fifo0 <= word_nxt;
          end else begin
            fifo0 <= fifo1;
            fifo1 <= word_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state               <= W_IDLE;
      bus.do_write        <= 1'b0;
      bus.where_write     <= BASE;
      bus.data_to_write   <= '0;
      bus.last_write_done <= 1'b0;
      wr_idx              <= '0;
      stale               <= 1'b0;
    end else begin
      unique case (state)
        W_IDLE: begin
          if (pop) begin
            bus.data_to_write <= fifo0;
            bus.where_write   <=
              BASE + {11'd0, wr_idx} * STEP;
            bus.do_write      <= 1'b1;
            wr_idx            <= wr_idx + 17'd1;
            stale             <= 1'b0;
            state             <= W_REQ;
          end
        end
        W_REQ: begin
          if (bus.ack) begin
            bus.do_write <= 1'b0;
            state        <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (!bus.ack && !bus.is_writing) begin
            if (!stale && !bus.frame_start &&
                wr_idx == WORDS)
              bus.last_write_done <= 1'b1;
            state <= W_IDLE;
          end
        end
        default: state <= W_IDLE;
      endcase
      // An in-flight write finishes at its old address but is
      // marked so it cannot signal completion of the new frame.
      if (bus.frame_start) begin
        wr_idx              <= '0;
        bus.last_write_done <= 1'b0;
        if (state != W_IDLE)
          stale <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mandel_pixel_packer.sv
// Randomised scoreboard bench for mandel_pixel_packer.
// Model packs accepted pixels into expected words per frame.
module tb_mandel_pixel_packer;
  localparam int PPF = 64;

  typedef struct {
    logic [27:0]  a;
    logic [127:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  mandel_pixel_packer_if bus ();

  mandel_pixel_packer #(
    .PIXELS_PER_FRAME(PPF),
    .ADDR_STEP(8),
    .BASE_ADDR(0)
  ) dut (
    .clk(clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  wr_t          exp_q[$];
  logic [15:0]  pq[$];
  int           pc;
  int           wk;
  int           wr_cnt;
  int           rise_cyc;
  int           acc8_cyc;
  bit           ack_block = 1'b0;
  bit           rnd = 1'b0;
  int           ack_dly = 1;
  int           ack_hold = 0;
  int           iw_len = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pq.delete();
    pc = 0;
    wk = 0;
  endtask

  task automatic model_accept(input logic [15:0] d);
    logic [127:0] w;
    pc++;
    chk("frame_len", pc <= PPF, 1);
    pq.push_back(d);
    if (pq.size() == 8) begin
      w = '0;
      for (int i = 0; i < 8; i++)
        w = {w[111:0], pq[i]};
      exp_q.push_back('{a: 28'(wk * 8), d: w});
      wk++;
      pq.delete();
      acc8_cyc = cyc;
    end
  endtask

  task automatic offer(input int max_acc,
                       input int max_cyc,
                       input bit gaps,
                       input bit seq,
                       output int acc);
    acc = 0;
    for (int c = 0; c < max_cyc && acc < max_acc; c++) begin
      @(negedge clk);
      #2;
      bus.pix_valid = gaps ?
        ($urandom_range(0, 3) != 0) : 1'b1;
      bus.pix_data = seq ? 16'(acc + 1) : 16'($urandom);
      #1;
      if (bus.pix_valid && bus.pix_ready) begin
        model_accept(bus.pix_data);
        acc++;
      end
    end
    @(negedge clk);
    #2;
    bus.pix_valid = 1'b0;
  endtask

  task automatic start_frame();
    @(negedge clk);
    #2;
    model_reset();
    wr_cnt = 0;
    bus.frame_start = 1'b1;
    @(negedge clk);
    #2;
    bus.frame_start = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.do_write &&
          !bus.ack && !bus.is_writing)
        ok = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk("drain", ok, 1);
  endtask

  task automatic wait_ldw(input int lim);
    for (int i = 0; i < lim && !bus.last_write_done; i++)
      @(negedge clk);
    chk("last_write_done", bus.last_write_done, 1);
  endtask

  // Scoreboard monitor: compares every new request.
  logic         prev_dw = 1'b0;
  logic [27:0]  la;
  logic [127:0] ld;
  wr_t          e_m;

  always @(negedge clk) begin
    if (sys_rst) begin
      prev_dw = 1'b0;
    end else begin
      if (bus.do_write && !prev_dw) begin
        wr_cnt++;
        rise_cyc = cyc;
        chk("req_gap", {bus.ack, bus.is_writing}, 0);
        chk("ldw_at_req", bus.last_write_done, 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0h want none",
                   bus.where_write);
        end else begin
          e_m = exp_q.pop_front();
          chk("addr", bus.where_write, e_m.a);
          chk("data", bus.data_to_write, e_m.d);
        end
        la = bus.where_write;
        ld = bus.data_to_write;
      end else if (bus.do_write) begin
        chk("addr_stable", bus.where_write, la);
        chk("data_stable", bus.data_to_write, ld);
      end
      prev_dw = bus.do_write;
    end
  end

  // DDR3 controller responder.
  int r_d;
  int r_n;
  int r_h;
  bit r_gone;

  initial begin
    bus.ack = 1'b0;
    bus.is_writing = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.do_write && !bus.ack && !sys_rst) begin
        r_d = rnd ? $urandom_range(1, 10) : ack_dly;
        r_n = 0;
        r_gone = 1'b0;
        while (!r_gone && (ack_block || r_n < r_d - 1)) begin
          @(negedge clk);
          r_n++;
          if (!bus.do_write) r_gone = 1'b1;
          if (r_n > 5000) begin
            chk("ack_block_timeout", 0, 1);
            r_gone = 1'b1;
          end
        end
        if (!r_gone) begin
          #2;
          bus.ack = 1'b1;
          bus.is_writing = 1'b1;
          r_n = 0;
          while (bus.do_write && r_n < 50) begin
            @(negedge clk);
            r_n++;
          end
          chk("dw_drop_on_ack", bus.do_write, 0);
          r_h = rnd ? $urandom_range(0, 9) : ack_hold;
          repeat (r_h) @(negedge clk);
          #2;
          bus.ack = 1'b0;
          r_h = rnd ? $urandom_range(0, 9) : iw_len;
          repeat (r_h) @(negedge clk);
          #2;
          bus.is_writing = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  int acc;

  initial begin
    bus.frame_start = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data = '0;
    model_reset();
    wr_cnt = 0;
    repeat (3) @(negedge clk);
    chk("rst_do_write", bus.do_write, 0);
    chk("rst_where", bus.where_write, 0);
    chk("rst_data", bus.data_to_write, 0);
    chk("rst_ready", bus.pix_ready, 0);
    chk("rst_ldw", bus.last_write_done, 0);
    #2;
    sys_rst = 1'b0;

    // word packing and first-word latency
    ack_dly = 1;
    ack_hold = 0;
    iw_len = 3;
    start_frame();
    offer(8, 50, 0, 1, acc);
    drain();
    chk("pack_cnt_writes", wr_cnt, 1);
    chk("pack_word", bus.data_to_write,
        128'h0001_0002_0003_0004_0005_0006_0007_0008);
    chk("pack_addr", bus.where_write, 0);
    chk("latency", rise_cyc - acc8_cyc, 2);

    // backpressure, then complete the frame
    iw_len = 0;
    ack_block = 1'b1;
    start_frame();
    offer(PPF, 40, 0, 0, acc);
    chk("stall_count", acc, 31);
    chk("stall_ready", bus.pix_ready, 0);
    ack_block = 1'b0;
    offer(PPF - 31, 500, 0, 0, acc);
    chk("bp_rest", acc, PPF - 31);
    wait_ldw(300);
    drain();
    chk("bp_writes", wr_cnt, 8);

    // full frame with random handshake timing
    rnd = 1'b1;
    start_frame();
    chk("ldw_cleared", bus.last_write_done, 0);
    offer(PPF, 3000, 1, 0, acc);
    chk("full_pixels", acc, PPF);
    offer(1, 5, 0, 0, acc);
    chk("pix65_refused", acc, 0);
    wait_ldw(1000);
    drain();
    chk("full_writes", wr_cnt, 8);
    rnd = 1'b0;

    // ack held high after do_write drops
    ack_hold = 6;
    iw_len = 2;
    start_frame();
    offer(16, 200, 0, 0, acc);
    drain();
    chk("hold_writes", wr_cnt, 2);
    ack_hold = 0;
    iw_len = 1;

    // restart while word 3 is in W_REQ
    start_frame();
    offer(16, 200, 0, 0, acc);
    drain();
    ack_block = 1'b1;
    offer(8, 50, 0, 0, acc);
    for (int i = 0; i < 20 && !bus.do_write; i++)
      @(negedge clk);
    chk("w3_addr", bus.where_write, 16);
    offer(5, 50, 0, 0, acc);
    start_frame();
    ack_block = 1'b0;
    drain();
    chk("stale_ldw", bus.last_write_done, 0);
    offer(8, 50, 0, 0, acc);
    drain();
    chk("restart_writes", wr_cnt, 1);
    chk("restart_addr", bus.where_write, 0);
    chk("restart_ldw", bus.last_write_done, 0);
    offer(PPF - 8, 500, 1, 0, acc);
    wait_ldw(500);
    drain();

    // async reset mid-handshake
    ack_block = 1'b1;
    start_frame();
    offer(13, 100, 0, 0, acc);
    chk("dw_before_rst", bus.do_write, 1);
    @(negedge clk);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("arst_do_write", bus.do_write, 0);
    chk("arst_where", bus.where_write, 0);
    chk("arst_data", bus.data_to_write, 0);
    chk("arst_ready", bus.pix_ready, 0);
    chk("arst_ldw", bus.last_write_done, 0);
    @(negedge clk);
    #2;
    sys_rst = 1'b0;
    model_reset();
    ack_block = 1'b0;
    start_frame();
    offer(8, 50, 0, 0, acc);
    drain();
    chk("arst_writes", wr_cnt, 1);
    chk("arst_addr0", bus.where_write, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
